// File: rtl/controlador_cruzamento.sv
// Four-approach intersection controller: round-robin vehicle green phase shared
// with a pedestrian walk, timed green/amber/all-red intervals, registered heads.
module controlador_cruzamento #(
    parameter logic [7:0] T_VERDE    = 8'd5,
    parameter logic [7:0] T_AMARELO  = 8'd3,
    parameter logic [7:0] T_VERMELHO = 8'd2,
    parameter logic [7:0] T_PEDESTRE = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        bt,
    output logic [11:0] luzes,
    output logic        andar,
    output logic [1:0]  fase
);

    localparam int unsigned TMR_W   = 8;
    localparam int unsigned N_APR   = 4;
    localparam int unsigned FASE_W  = 2;
    localparam int unsigned COR_W   = 3;
    localparam int unsigned LUZES_W = N_APR * COR_W;

    localparam logic [COR_W-1:0] COR_VERMELHO = 3'b100;
    localparam logic [COR_W-1:0] COR_AMARELO  = 3'b010;
    localparam logic [COR_W-1:0] COR_VERDE    = 3'b001;

    // Reload values: a duration of 0 behaves as 1, so the load clamps at 0.
    localparam logic [TMR_W-1:0] LD_VERDE    = (T_VERDE    == 8'd0) ? 8'd0 : T_VERDE    - 8'd1;
    localparam logic [TMR_W-1:0] LD_AMARELO  = (T_AMARELO  == 8'd0) ? 8'd0 : T_AMARELO  - 8'd1;
    localparam logic [TMR_W-1:0] LD_VERMELHO = (T_VERMELHO == 8'd0) ? 8'd0 : T_VERMELHO - 8'd1;
    localparam logic [TMR_W-1:0] LD_PEDESTRE = (T_PEDESTRE == 8'd0) ? 8'd0 : T_PEDESTRE - 8'd1;

    typedef enum logic [1:0] {
        VERMELHO = 2'd0,
        VERDE    = 2'd1,
        AMARELO  = 2'd2,
        PEDESTRE = 2'd3
    } estado_t;

    estado_t              r_estado;
    logic [TMR_W-1:0]     r_timer;
    logic [N_APR-1:0]     r_req_pend;
    logic                 r_ped_pend;
    logic                 r_ult_ped;
    logic [FASE_W-1:0]    r_fase;
    logic [LUZES_W-1:0]   r_luzes;
    logic                 r_andar;

    estado_t              w_estado_nx;
    logic [TMR_W-1:0]     w_timer_nx;
    logic [N_APR-1:0]     w_req_pend_nx;
    logic                 w_ped_pend_nx;
    logic                 w_ult_ped_nx;
    logic [FASE_W-1:0]    w_fase_nx;
    logic [LUZES_W-1:0]   w_luzes_nx;
    logic                 w_andar_nx;

    logic                 w_timer_zero;
    logic [N_APR-1:0]     w_veh;
    logic                 w_ped;
    logic [FASE_W-1:0]    w_sel;
    logic                 w_found;

    assign w_timer_zero = (r_timer == '0);
    assign w_veh        = r_req_pend | req;
    assign w_ped        = r_ped_pend | bt;

    // Round-robin pick: first requesting approach after the last vehicle grant.
    always_comb begin
        w_sel   = r_fase;
        w_found = 1'b0;
        for (int k = 1; k <= int'(N_APR); k++) begin
            if (!w_found && w_veh[FASE_W'(r_fase + FASE_W'(k))]) begin
                w_sel   = FASE_W'(r_fase + FASE_W'(k));
                w_found = 1'b1;
            end
        end
    end

    // State register; heads are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_estado   <= VERMELHO;
            r_timer    <= LD_VERMELHO;
            r_req_pend <= '0;
            r_ped_pend <= 1'b0;
            r_ult_ped  <= 1'b0;
            r_fase     <= FASE_W'(N_APR - 1);
            r_luzes    <= {N_APR{COR_VERMELHO}};
            r_andar    <= 1'b0;
        end else begin
            r_estado   <= w_estado_nx;
            r_timer    <= w_timer_nx;
            r_req_pend <= w_req_pend_nx;
            r_ped_pend <= w_ped_pend_nx;
            r_ult_ped  <= w_ult_ped_nx;
            r_fase     <= w_fase_nx;
            r_luzes    <= w_luzes_nx;
            r_andar    <= w_andar_nx;
        end
    end

    // Next-state, timer, pending latches and grant pointer.
    always_comb begin
        w_estado_nx   = r_estado;
        w_timer_nx    = w_timer_zero ? '0 : r_timer - TMR_W'(1);
        w_req_pend_nx = r_req_pend | req;
        w_ped_pend_nx = r_ped_pend | bt;
        w_ult_ped_nx  = r_ult_ped;
        w_fase_nx     = r_fase;

        unique case (r_estado)
            VERDE: begin
                if (w_timer_zero) begin
                    w_estado_nx = AMARELO;
                    w_timer_nx  = LD_AMARELO;
                end
            end
            AMARELO: begin
                if (w_timer_zero) begin
                    w_estado_nx = VERMELHO;
                    w_timer_nx  = LD_VERMELHO;
                end
            end
            PEDESTRE: begin
                if (w_timer_zero) begin
                    w_estado_nx = VERMELHO;
                    w_timer_nx  = LD_VERMELHO;
                end
            end
            VERMELHO: begin
                // A vehicle waiting after a walk takes precedence over another walk.
                if (w_timer_zero) begin
                    if (w_ped && !(r_ult_ped && w_found)) begin
                        w_estado_nx   = PEDESTRE;
                        w_timer_nx    = LD_PEDESTRE;
                        w_ped_pend_nx = 1'b0;
                        w_ult_ped_nx  = 1'b1;
                    end else if (w_found) begin
                        w_estado_nx              = VERDE;
                        w_timer_nx               = LD_VERDE;
                        w_req_pend_nx[w_sel]     = 1'b0;
                        w_ult_ped_nx             = 1'b0;
                        w_fase_nx                = w_sel;
                    end
                end
            end
            default: begin
                w_estado_nx = VERMELHO;
                w_timer_nx  = LD_VERMELHO;
            end
        endcase
    end

    // Head decode from the upcoming state; only the granted approach leaves red.
    always_comb begin
        w_luzes_nx = {N_APR{COR_VERMELHO}};
        w_andar_nx = (w_estado_nx == PEDESTRE);
        for (int i = 0; i < int'(N_APR); i++) begin
            if (FASE_W'(i) == w_fase_nx) begin
                if (w_estado_nx == VERDE) begin
                    w_luzes_nx[i*COR_W +: COR_W] = COR_VERDE;
                end else if (w_estado_nx == AMARELO) begin
                    w_luzes_nx[i*COR_W +: COR_W] = COR_AMARELO;
                end
            end
        end
    end

    assign luzes = r_luzes;
    assign andar = r_andar;
    assign fase  = r_fase;

endmodule

// File: tb/tb_controlador_cruzamento.sv
// Directed bench for controlador_cruzamento with hand-computed head patterns.
module tb_controlador_cruzamento;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        bt;
    logic [11:0] luzes;
    logic        andar;
    logic [1:0]  fase;

    int n_checks;
    int n_pass;

    localparam logic [11:0] RED_ALL = 12'h924;
    localparam logic [11:0] G0      = 12'h921;
    localparam logic [11:0] A0      = 12'h922;
    localparam logic [11:0] G1      = 12'h90C;
    localparam logic [11:0] G2      = 12'h864;
    localparam logic [11:0] A2      = 12'h8A4;
    localparam logic [11:0] G3      = 12'h324;

    controlador_cruzamento dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .bt    (bt),
        .luzes (luzes),
        .andar (andar),
        .fase  (fase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    logic [11:0] exp_l;
    logic [1:0]  ordem [6];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        req = 4'b0000;
        bt  = 1'b0;
        ordem[0] = 2'd0; ordem[1] = 2'd1; ordem[2] = 2'd3;
        ordem[3] = 2'd0; ordem[4] = 2'd1; ordem[5] = 2'd3;

        // Reset and idle
        do_reset();
        check("rst_luzes", 32'(luzes), 32'(RED_ALL));
        check("rst_andar", 32'(andar), 32'd0);
        check("rst_fase",  32'(fase),  32'd3);
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("idle_luzes", 32'(luzes), 32'(RED_ALL));
        end
        check("idle_fase", 32'(fase), 32'd3);

        // Single request on approach 2
        req = 4'b0100;
        tick(1);
        req = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            exp_l = (c < 5) ? G2 : (c < 8) ? A2 : RED_ALL;
            check("single_luzes", 32'(luzes), 32'(exp_l));
            check("single_andar", 32'(andar), 32'd0);
            tick(1);
        end
        check("single_fase", 32'(fase), 32'd2);
        tick(5);
        check("single_done", 32'(luzes), 32'(RED_ALL));

        // Round robin with req held from reset
        req = 4'b1011;
        do_reset();
        tick(1);
        check("rr_clear", 32'(luzes), 32'(RED_ALL));
        tick(1);
        for (int g = 0; g < 6; g++) begin
            if (g > 0) begin
                tick(9);
                check("rr_gap", 32'(luzes), 32'(RED_ALL));
                tick(1);
            end
            exp_l = (ordem[g] == 2'd0) ? G0 : (ordem[g] == 2'd1) ? G1 : G3;
            check("rr_luzes", 32'(luzes), 32'(exp_l));
            check("rr_fase",  32'(fase),  32'(ordem[g]));
        end
        req = 4'b0000;

        // Pedestrian during approach-1 green with approach 3 pending
        do_reset();
        tick(3);
        req = 4'b0010;
        tick(1);
        check("ped_g1", 32'(luzes), 32'(G1));
        req = 4'b1000;
        bt  = 1'b1;
        tick(1);
        req = 4'b0000;
        bt  = 1'b0;
        tick(8);
        check("ped_pre_red",  32'(luzes), 32'(RED_ALL));
        check("ped_pre_walk", 32'(andar), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick(1);
            check("ped_walk",  32'(andar), 32'd1);
            check("ped_red",   32'(luzes), 32'(RED_ALL));
            check("ped_fase",  32'(fase),  32'd1);
        end
        tick(1);
        check("ped_end", 32'(andar), 32'd0);
        tick(1);
        check("ped_clear", 32'(luzes), 32'(RED_ALL));
        tick(1);
        check("ped_g3",   32'(luzes), 32'(G3));
        check("ped_f3",   32'(fase),  32'd3);

        // Anti-starvation: bt and req[0] held
        bt  = 1'b1;
        req = 4'b0001;
        do_reset();
        tick(2);
        for (int r = 0; r < 3; r++) begin
            check("as_walk", 32'(andar), 32'd1);
            check("as_walk_red", 32'(luzes), 32'(RED_ALL));
            tick(5);
            check("as_walk_clear", 32'(andar), 32'd0);
            tick(1);
            check("as_g0", 32'(luzes), 32'(G0));
            check("as_g0_andar", 32'(andar), 32'd0);
            tick(10);
        end
        bt  = 1'b0;
        req = 4'b0000;

        // Mid-cycle reset during amber with approach 3 pending
        do_reset();
        tick(3);
        req = 4'b0001;
        tick(1);
        check("mr_g0", 32'(luzes), 32'(G0));
        req = 4'b1000;
        tick(1);
        req = 4'b0000;
        tick(4);
        check("mr_amber", 32'(luzes), 32'(A0));
        rst = 1'b0;
        tick(1);
        check("mr_rst_luzes", 32'(luzes), 32'(RED_ALL));
        check("mr_rst_fase",  32'(fase),  32'd3);
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            check("mr_idle", 32'(luzes), 32'(RED_ALL));
        end
        check("mr_idle_fase", 32'(fase), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
